// File: rtl/ai_accel_op_scheduler.sv
// In-order command sequencer for the accelerator compute engines: buffers opcode/argument
// commands in a small FIFO, starts one engine at a time and waits for its done under a watchdog.
module ai_accel_op_scheduler #(
    parameter int NUM_ENG    = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int ARG_W      = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_op,
    input  logic [ARG_W-1:0]              cmd_arg,
    input  logic                          abort,
    input  logic                          err_clear,
    output logic [NUM_ENG-1:0]            eng_start,
    output logic [ARG_W-1:0]              eng_arg,
    input  logic [NUM_ENG-1:0]            eng_done,
    output logic                          op_done,
    output logic [2:0]                    op_done_id,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_badop,
    output logic                          err_timeout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 2);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [3:0]       NUM_ENG_L = 4'(NUM_ENG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [2:0]       fifo_op  [FIFO_DEPTH];
    logic [ARG_W-1:0] fifo_arg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;

    logic [2:0]         op_q;
    logic [ARG_W-1:0]   arg_q;
    logic [WD_W-1:0]    wd_cnt;
    logic [NUM_ENG-1:0] eng_start_q;
    logic               op_done_q;
    logic [2:0]         op_done_id_q;

    logic               empty, full, push, pop;
    logic               head_bad, done_hit, badop_fire, timeout_fire, finish_ok;
    logic [2:0]         head_op;
    logic [ARG_W-1:0]   head_arg;
    logic [NUM_ENG-1:0] op_onehot;

    assign empty     = (level == '0);
    assign full      = (level == LVL_FULL);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full && !abort;
    assign head_op   = fifo_op[rd_ptr];
    assign head_arg  = fifo_arg[rd_ptr];
    assign head_bad  = ({1'b0, head_op} >= NUM_ENG_L);
    assign op_onehot = {{(NUM_ENG-1){1'b0}}, 1'b1} << op_q;
    assign done_hit  = |(eng_done & op_onehot);
    assign finish_ok = (state == S_WAIT) && !abort && done_hit;

    // Storage array carries no reset; occupancy is tracked by the pointers and level below.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= cmd_op;
            fifo_arg[wr_ptr] <= cmd_arg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state   = state;
        pop          = 1'b0;
        badop_fire   = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !empty && !abort) begin
                    pop = 1'b1;
                    if (head_bad) badop_fire = 1'b1;
                    else          next_state = S_ISSUE;
                end
            end
            S_ISSUE: next_state = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    next_state = S_IDLE;
                end else if (done_hit) begin
                    next_state = S_DONE;
                end else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
                    timeout_fire = 1'b1;
                    next_state   = S_IDLE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Start and completion pulses are registered, so the engine sees start one cycle after ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q         <= '0;
            arg_q        <= '0;
            wd_cnt       <= '0;
            eng_start_q  <= '0;
            op_done_q    <= 1'b0;
            op_done_id_q <= '0;
            err_badop    <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (pop && !head_bad) begin
                op_q  <= head_op;
                arg_q <= head_arg;
            end
            wd_cnt      <= (state == S_WAIT) ? wd_cnt + WD_W'(1) : '0;
            eng_start_q <= (state == S_ISSUE && !abort) ? op_onehot : '0;
            op_done_q   <= finish_ok;
            if (finish_ok) op_done_id_q <= op_q;
            err_badop   <= badop_fire   || (err_badop   && !err_clear);
            err_timeout <= timeout_fire || (err_timeout && !err_clear);
        end
    end

    assign eng_start  = eng_start_q;
    assign eng_arg    = arg_q;
    assign op_done    = op_done_q;
    assign op_done_id = op_done_id_q;
    assign busy       = (state != S_IDLE) || !empty;
    assign fifo_level = level;

endmodule
